dl11_console_fifo: RTL and testbench

//  Synthesizable DL11-style console serial register block for the vm1 bus; replaces the bench-only
//  177560..177566 console model. Bus slave with RCSR/RBUF/XCSR/XBUF, parametrised TX/RX FIFOs,

---
 rtl/dl11_pkg.sv | 42 ++++
 rtl/dl11_byte_fifo.sv | 69 ++++++
 rtl/dl11_console_fifo.sv | 249 ++++++++++++++++++++++++
 tb/tb_dl11_console_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl11_pkg.sv
// dl11_pkg: shared definitions for the DL11-style console register block.
//   - byte offsets of RCSR/RBUF/XCSR/XBUF from the base address
//   - CSR bit positions (DONE/READY, IE, MAINT)
//   - bus FSM state enum and the captured bus request record
//   - csr_word(): assembles a status register read value
package dl11_pkg;

   localparam logic [2:0] OFF_RCSR = 3'o0;
   localparam logic [2:0] OFF_RBUF = 3'o2;
   localparam logic [2:0] OFF_XCSR = 3'o4;
   localparam logic [2:0] OFF_XBUF = 3'o6;

   localparam int BIT_DONE  = 7;
   localparam int BIT_READY = 7;
   localparam int BIT_IE    = 6;
   localparam int BIT_MAINT = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_REPLY = 2'd2
   } dl11_state_e;

   // One bus cycle as seen when the strobe is detected.
   typedef struct packed {
      logic       iack;   // interrupt acknowledge (IAKO & DIN)
      logic       rd;     // DIN cycle
      logic       hi;     // byte write to the odd (high) byte
      logic [2:0] off;    // register byte offset, bit 0 forced to 0
      logic [7:0] wdata;  // low byte of the write data
   } dl11_req_t;

   function automatic logic [15:0] csr_word(input logic flag, input logic ie, input logic mnt);
      logic [15:0] w;
      w            = '0;
      w[BIT_DONE]  = flag;
      w[BIT_IE]    = ie;
      w[BIT_MAINT] = mnt;
      return w;
   endfunction

endpackage

// File: rtl/dl11_byte_fifo.sv
// dl11_byte_fifo: byte-wide synchronous FIFO used for the TX and RX paths.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        synchronous flush (bus INIT)
//   push, din    write request and data; accepted when not full or when a pop
//                happens in the same clock (pop frees the slot first)
//   pop          read request; ignored when empty
//   dout         current head entry
//   full, empty  status flags
//   count        number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module dl11_byte_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dl11_console_fifo.sv
// dl11_console_fifo: DL11-style console serial register block for the vm1 bus.
// Registers at BASE_ADDR: RCSR(+0) RBUF(+2) XCSR(+4) XBUF(+6), backed by
// byte FIFOs towards a UART or bench source/sink, with RX/TX interrupts.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   addr_i, data_i    bus address (with SYNC) and write data (with DOUT)
//   data_o            read data / interrupt vector while replying, else 0
//   SYNC DIN DOUT     address, read and write strobes
//   WTBT              byte access; odd-byte writes are ignored
//   IAKO              interrupt acknowledge, qualified by DIN
//   INIT              synchronous soft reset of registers and FIFOs
//   RPLY, VIRQ        reply and interrupt request
//   tx_data/valid/ready  TX byte stream out (pop when valid & ready)
//   rx_data/valid/ready  RX byte stream in (push when valid & ready)
//   dbg_state         bus FSM state
//   dbg_tx_count, dbg_rx_count  FIFO fill levels
// Handshake: a byte moves on a stream port in any clock where valid and
// ready are both high at the rising edge; valid never depends on ready.
// Optional feature: CONSOLE_LOOPBACK_EN adds XCSR bit 2 (MAINT), which feeds
// the TX FIFO head straight into the RX FIFO and silences the TX stream.
module dl11_console_fifo
   import dl11_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'o177560,
   parameter int unsigned TX_DEPTH  = 16,
   parameter int unsigned RX_DEPTH  = 16,
   parameter int unsigned WAIT      = 0,
   parameter logic [15:0] VEC_RX    = 16'o60,
   parameter logic [15:0] VEC_TX    = 16'o64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [15:0]                 addr_i,
   input  logic [15:0]                 data_i,
   output logic [15:0]                 data_o,
   input  logic                        SYNC,
   input  logic                        DIN,
   input  logic                        DOUT,
   input  logic                        WTBT,
   input  logic                        IAKO,
   input  logic                        INIT,
   output logic                        RPLY,
   output logic                        VIRQ,
   output logic [7:0]                  tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   output dl11_state_e                 dbg_state,
   output logic [$clog2(TX_DEPTH):0]   dbg_tx_count,
   output logic [$clog2(RX_DEPTH):0]   dbg_rx_count
);

   localparam logic [2:0] WAIT_LAST = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

   dl11_state_e state, state_nx;
   logic [2:0]  wcnt;
   dl11_req_t   req_new, req_q, req_cur;
   logic        start_acc, start_iack, enter_reply;

   logic        rx_ie, tx_ie, tx_ie_nx, tx_arm, ready_q, maint;
   logic        rx_irq, tx_rdy;
   logic        do_rd, do_wr, iack_go, tx_ack, ie_rise, ready_rise;
   logic        rcsr_wr, xcsr_wr, tx_push_bus, rx_pop_bus;
   logic [15:0] rdata;

   logic [7:0]  tx_head, rx_head, rx_din;
   logic        tx_full, tx_empty, rx_full, rx_empty;
   logic        tx_pop, rx_push;

   logic        unused_bits;
   assign unused_bits = ^data_i[15:8];

   // ---------------- request capture ----------------
   assign req_new = '{iack:  IAKO & DIN,
                      rd:    DIN,
                      hi:    WTBT & addr_i[0],
                      off:   {addr_i[2:1], 1'b0},
                      wdata: data_i[7:0]};

   assign start_iack = IAKO & DIN & VIRQ;
   assign start_acc  = SYNC & ~IAKO & (DIN | DOUT) & (addr_i[15:3] == BASE_ADDR[15:3]);

   // With WAIT=0 the reply is entered in the detect clock, so the live
   // request is used there; otherwise the captured one.
   assign req_cur = (state == ST_IDLE) ? req_new : req_q;

   // ---------------- bus FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         wcnt  <= '0;
         req_q <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE) begin
            wcnt <= '0;
            if (start_acc || start_iack) req_q <= req_new;
         end else if (state == ST_WAIT) begin
            wcnt <= wcnt + 3'd1;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      enter_reply = 1'b0;
      if (INIT) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_acc || start_iack) begin
                  if (WAIT == 0) begin
                     state_nx    = ST_REPLY;
                     enter_reply = 1'b1;
                  end else begin
                     state_nx = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wcnt == WAIT_LAST) begin
                  state_nx    = ST_REPLY;
                  enter_reply = 1'b1;
               end
            end
            ST_REPLY: begin
               if (!DIN && !DOUT) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   assign RPLY      = (state == ST_REPLY);
   assign dbg_state = state;

   // ---------------- register side effects (once, on reply entry) ----------------
   assign rx_irq      = rx_ie & ~rx_empty;
   assign tx_rdy      = ~tx_full;
   assign VIRQ        = rx_irq | tx_arm;

   assign iack_go     = enter_reply & req_cur.iack;
   assign do_rd       = enter_reply & ~req_cur.iack & req_cur.rd;
   assign do_wr       = enter_reply & ~req_cur.iack & ~req_cur.rd & ~req_cur.hi;
   assign rcsr_wr     = do_wr & (req_cur.off == OFF_RCSR);
   assign xcsr_wr     = do_wr & (req_cur.off == OFF_XCSR);
   assign tx_push_bus = do_wr & (req_cur.off == OFF_XBUF);
   assign rx_pop_bus  = do_rd & (req_cur.off == OFF_RBUF) & ~rx_empty;

   // RX wins the acknowledge; only a TX acknowledge consumes tx_arm.
   assign tx_ack      = iack_go & ~rx_irq;
   assign tx_ie_nx    = xcsr_wr ? req_cur.wdata[BIT_IE] : tx_ie;
   assign ie_rise     = xcsr_wr & req_cur.wdata[BIT_IE] & ~tx_ie & tx_rdy;
   assign ready_rise  = tx_rdy & ~ready_q;

   always_comb begin
      rdata = '0;
      if (iack_go) begin
         rdata = rx_irq ? VEC_RX : VEC_TX;
      end else if (do_rd) begin
         case (req_cur.off)
            OFF_RCSR: rdata = csr_word(~rx_empty, rx_ie, 1'b0);
            OFF_RBUF: rdata = rx_empty ? 16'd0 : {8'd0, rx_head};
            OFF_XCSR: rdata = csr_word(tx_rdy, tx_ie, maint);
            default:  rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_ie   <= 1'b0;
         tx_ie   <= 1'b0;
         tx_arm  <= 1'b0;
         ready_q <= 1'b1;
         data_o  <= '0;
      end else if (INIT) begin
         rx_ie   <= 1'b0;
         tx_ie   <= 1'b0;
         tx_arm  <= 1'b0;
         ready_q <= 1'b1;
         data_o  <= '0;
      end else begin
         if (rcsr_wr) rx_ie <= req_cur.wdata[BIT_IE];
         tx_ie   <= tx_ie_nx;
         ready_q <= tx_rdy;
         // A set event beats a same-clock acknowledge so no TX edge is lost.
         if (!tx_ie_nx)                 tx_arm <= 1'b0;
         else if (ready_rise || ie_rise) tx_arm <= 1'b1;
         else if (tx_ack)               tx_arm <= 1'b0;
         if (enter_reply)               data_o <= rdata;
         else if (state_nx != ST_REPLY) data_o <= '0;
      end
   end

   // ---------------- stream routing ----------------
`ifdef CONSOLE_LOOPBACK_EN
   logic lb_move;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        maint <= 1'b0;
      else if (INIT)    maint <= 1'b0;
      else if (xcsr_wr) maint <= req_cur.wdata[BIT_MAINT];
   end
   assign lb_move  = maint & ~tx_empty & ~rx_full;
   assign tx_valid = ~maint & ~tx_empty;
   assign tx_pop   = maint ? lb_move : (tx_valid & tx_ready);
   assign rx_push  = maint ? lb_move : rx_valid;
   assign rx_din   = maint ? tx_head : rx_data;
`else
   assign maint    = 1'b0;
   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid;
   assign rx_din   = rx_data;
`endif

   assign tx_data  = tx_head;
   assign rx_ready = ~rx_full;

   dl11_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (INIT),
      .push  (tx_push_bus),
      .din   (req_cur.wdata),
      .pop   (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (dbg_tx_count)
   );

   dl11_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (INIT),
      .push  (rx_push),
      .din   (rx_din),
      .pop   (rx_pop_bus),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (dbg_rx_count)
   );

endmodule

// File: tb/tb_dl11_console_fifo.sv
// Testbench for dl11_console_fifo (3 wait states, 16-entry FIFOs).
module tb_dl11_console_fifo;
   import dl11_pkg::*;

   localparam logic [15:0] A_RCSR = 16'o177560;
   localparam logic [15:0] A_RBUF = 16'o177562;
   localparam logic [15:0] A_XCSR = 16'o177564;
   localparam logic [15:0] A_XBUF = 16'o177566;

   logic        clk, reset;
   logic [15:0] addr_i, data_i, data_o;
   logic        SYNC, DIN, DOUT, WTBT, IAKO, INIT, RPLY, VIRQ;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready;
   dl11_state_e dbg_state;
   logic [4:0]  dbg_tx_count, dbg_rx_count;

   dl11_console_fifo #(.WAIT(3)) dut (
      .clk(clk), .reset(reset), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
      .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT), .IAKO(IAKO), .INIT(INIT),
      .RPLY(RPLY), .VIRQ(VIRQ), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .dbg_state(dbg_state),
      .dbg_tx_count(dbg_tx_count), .dbg_rx_count(dbg_rx_count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  tx_exp_q[$];
   logic        rply_q = 1'b0;
   logic [15:0] mon_e;
   logic [7:0]  mon_t;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0o expected %0o", name, act, exp);
   endtask

   // Every rising RPLY must match the next expected reply word.
   always @(negedge clk) begin
      if (RPLY && !rply_q) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL reply_unexpected: got %0o expected no reply", data_o);
         end else begin
            mon_e = exp_q.pop_front();
            check("reply_data", data_o, mon_e);
         end
      end
      rply_q = RPLY;
   end

   // Every TX byte handed out must match the next expected byte.
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         if (tx_exp_q.size() == 0) begin
            n_total++;
            $display("FAIL tx_unexpected: got %0o expected none", tx_data);
         end else begin
            mon_t = tx_exp_q.pop_front();
            check("tx_data", 16'(tx_data), 16'(mon_t));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic bus(input logic rd, input logic iack, input logic [15:0] a,
                      input logic [15:0] wd, input logic wtbt, input logic [15:0] exp);
      int n;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      addr_i = a; data_i = wd; WTBT = wtbt; IAKO = iack; SYNC = ~iack;
      DIN = rd; DOUT = ~rd;
      n = 0;
      do begin @(negedge clk); n++; end while (!RPLY && n < 20);
      if (!RPLY) begin
         n_total++;
         $display("FAIL reply_timeout: addr %0o got no RPLY expected RPLY", a);
         void'(exp_q.pop_back());
      end
      @(posedge clk); #1;
      DIN = 0; DOUT = 0; SYNC = 0; IAKO = 0; WTBT = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (RPLY && n < 10);
      if (RPLY) begin
         n_total++;
         $display("FAIL reply_release: got RPLY=1 expected 0");
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus(1'b0, 1'b0, a, d, 1'b0, 16'd0);
   endtask
   task automatic wrb(input logic [15:0] a, input logic [15:0] d);
      bus(1'b0, 1'b0, a, d, 1'b1, 16'd0);
   endtask
   task automatic rd(input logic [15:0] a, input logic [15:0] exp);
      bus(1'b1, 1'b0, a, 16'd0, 1'b0, exp);
   endtask
   task automatic iack(input logic [15:0] exp);
      bus(1'b1, 1'b1, 16'd0, 16'd0, 1'b0, exp);
   endtask

   task automatic rx_send(input logic [7:0] b);
      @(posedge clk); #1; rx_data = b; rx_valid = 1;
      @(posedge clk); #1; rx_valid = 0;
   endtask

   task automatic tx_drain(input int cycles);
      @(posedge clk); #1; tx_ready = 1;
      repeat (cycles) @(posedge clk);
      #1; tx_ready = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          n;
      logic        seen;
      logic [15:0] v;

      reset = 1; addr_i = 0; data_i = 0; SYNC = 0; DIN = 0; DOUT = 0; WTBT = 0;
      IAKO = 0; INIT = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
      repeat (3) @(posedge clk);
      #1; reset = 0;
      @(negedge clk);
      check("reset_rply", 16'(RPLY), 16'd0);
      check("reset_virq", 16'(VIRQ), 16'd0);
      check("reset_data_o", data_o, 16'd0);
      check("reset_tx_valid", 16'(tx_valid), 16'd0);
      check("reset_rx_ready", 16'(rx_ready), 16'd1);
      check("reset_state", 16'(dbg_state), 16'(ST_IDLE));

      // 1: single XBUF write reaches the TX stream
      wr(A_XBUF, 16'o101);
      @(negedge clk);
      check("t1_tx_valid", 16'(tx_valid), 16'd1);
      check("t1_tx_head", 16'(tx_data), 16'o101);
      tx_exp_q.push_back(8'o101);
      tx_drain(1);
      @(negedge clk);
      check("t1_tx_empty", 16'(tx_valid), 16'd0);

      // 2: fill TX FIFO, overflow write dropped
      for (int i = 0; i < 16; i++) begin
         v = 16'o40 + 16'(i);
         wr(A_XBUF, v);
         tx_exp_q.push_back(v[7:0]);
      end
      rd(A_XCSR, 16'o0);
      wr(A_XBUF, 16'o377);
      @(negedge clk);
      check("t2_tx_count", 16'(dbg_tx_count), 16'd16);
      tx_drain(20);
      @(negedge clk);
      check("t2_tx_drained", 16'(tx_valid), 16'd0);
      check("t2_tx_exp_left", 16'(tx_exp_q.size()), 16'd0);
      rd(A_XCSR, 16'o200);

      // 3: receive path
      rx_send(8'o123);
      rd(A_RCSR, 16'o200);
      rd(A_RBUF, 16'o123);
      rd(A_RCSR, 16'o0);
      rd(A_RBUF, 16'o0);
      @(negedge clk);
      check("t3_virq", 16'(VIRQ), 16'd0);

      // 4: interrupts and vectors
      wr(A_XCSR, 16'o100);
      @(negedge clk);
      check("t4_tx_virq", 16'(VIRQ), 16'd1);
      iack(16'o64);
      @(negedge clk);
      check("t4_tx_ack_clears", 16'(VIRQ), 16'd0);
      rd(A_XCSR, 16'o300);
      wr(A_RCSR, 16'o100);
      @(negedge clk);
      check("t4_rx_ie_no_data", 16'(VIRQ), 16'd0);
      rx_send(8'o7);
      @(negedge clk);
      check("t4_rx_virq", 16'(VIRQ), 16'd1);
      iack(16'o60);
      @(negedge clk);
      check("t4_rx_ack_keeps", 16'(VIRQ), 16'd1);
      rd(A_RBUF, 16'o7);
      @(negedge clk);
      check("t4_rbuf_clears", 16'(VIRQ), 16'd0);
      wr(A_RCSR, 16'o0);
      wr(A_XCSR, 16'o0);

      // byte writes: odd byte ignored, even byte acts
      wrb(A_XCSR + 16'd1, 16'o100);
      rd(A_XCSR, 16'o200);
      wrb(A_XBUF, 16'o55);
      wrb(A_XBUF + 16'd1, 16'o66);
      @(negedge clk);
      check("byte_tx_count", 16'(dbg_tx_count), 16'd1);
      tx_exp_q.push_back(8'o55);
      tx_drain(3);

      // RX FIFO full, overflow byte dropped
      for (int i = 0; i < 16; i++) rx_send(8'(i + 1));
      @(negedge clk);
      check("rx_full_ready", 16'(rx_ready), 16'd0);
      rx_send(8'o377);
      for (int i = 0; i < 16; i++) rd(A_RBUF, 16'(i + 1));
      rd(A_RBUF, 16'o0);
      @(negedge clk);
      check("rx_empty_ready", 16'(rx_ready), 16'd1);

      // 5a: wait-state latency
      exp_q.push_back(16'o0);
      @(posedge clk); #1; SYNC = 1; addr_i = A_RCSR; DIN = 1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!RPLY && n < 10);
      check("t5_latency", 16'(n), 16'd4);
      DIN = 0; SYNC = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t5_rply_drop", 16'(RPLY), 16'd0);

      // 5b: INIT during WAIT aborts the cycle and flushes the FIFOs
      rx_send(8'o11);
      @(posedge clk); #1; SYNC = 1; addr_i = A_RBUF; DIN = 1;
      @(posedge clk); #1; INIT = 1; DIN = 0; SYNC = 0;
      @(posedge clk); #1; INIT = 0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (RPLY) seen = 1; end
      check("t5_init_no_reply", 16'(seen), 16'd0);
      check("t5_init_state", 16'(dbg_state), 16'(ST_IDLE));
      check("t5_init_rx_count", 16'(dbg_rx_count), 16'd0);
      rd(A_RCSR, 16'o0);

      // 5c: reset during REPLY drops RPLY at once
      exp_q.push_back(16'o0);
      @(posedge clk); #1; SYNC = 1; addr_i = A_RCSR; DIN = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!RPLY && n < 20);
      if (!RPLY) begin
         n_total++;
         $display("FAIL t5_reset_reply_timeout: got no RPLY expected RPLY");
         void'(exp_q.pop_back());
      end
      #1; reset = 1;
      #1;
      check("t5_reset_rply", 16'(RPLY), 16'd0);
      check("t5_reset_data_o", data_o, 16'd0);
      SYNC = 0; DIN = 0;
      @(posedge clk); #1; reset = 0;
      rd(A_XCSR, 16'o200);

`ifdef CONSOLE_LOOPBACK_EN
      // 6: maintenance loopback
      wr(A_XCSR, 16'o4);
      rd(A_XCSR, 16'o204);
      wr(A_XBUF, 16'o252);
      repeat (3) @(negedge clk);
      check("t6_tx_valid", 16'(tx_valid), 16'd0);
      rd(A_RCSR, 16'o200);
      rd(A_RBUF, 16'o252);
      wr(A_XCSR, 16'o0);
`endif

      repeat (4) @(negedge clk);
      check("reply_queue_left", 16'(exp_q.size()), 16'd0);
      check("tx_queue_left", 16'(tx_exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
